// File: rtl/mem_arbiter_pkg.sv
// Shared constants, source tags and grant encoding for the frame-buffer SRAM arbiter.
package mem_arbiter_pkg;

    localparam int MEM_W       = 36;
    localparam int ADDR_W      = 19;
    localparam int FRAME_WORDS = 153600;
    localparam int READ_LAT    = 2;
    localparam int AGE_LIMIT   = 16;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_PROC = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_NTSC = 2'd2,
        GNT_PROC = 2'd3
    } grant_t;

    // Linear frame counter step: last word of the frame rolls back to 0.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] last);
        return (addr == last) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// SRAM pin bundle between the arbiter (master) and the ZBT SRAM (slave).
interface mem_arbiter_if import mem_arbiter_pkg::*; ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we_b;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;

    modport master (output mem_addr, mem_we_b, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_we_b, mem_wdata, output mem_rdata);

endinterface

// File: rtl/mem_tag_pipe.sv
// Source-tag shift register that tracks each issued command until its read data returns.
module mem_tag_pipe import mem_arbiter_pkg::*; #(
    parameter int DEPTH = READ_LAT + 1
) (
    input  logic clock,
    input  logic clear,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= TAG_NONE;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port ZBT frame-buffer arbiter: VGA read > NTSC write > processor access.
// Optional build macro MEM_ARBITER_PROC_AGING_EN lets a long-waiting processor outrank NTSC.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int FRAME_WORDS = mem_arbiter_pkg::FRAME_WORDS,
    parameter int READ_LAT    = mem_arbiter_pkg::READ_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_flag,
    input  logic              vga_flag,
    output logic [MEM_W-1:0]  vga_pixel,
    output logic              done_vga,
    input  logic              ntsc_flag,
    input  logic [MEM_W-1:0]  ntsc_pixel,
    output logic              ntsc_overflow,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [MEM_W-1:0]  proc_wdata,
    output logic              proc_ack,
    output logic [MEM_W-1:0]  proc_rdata,
    output logic              done_proc,
    mem_arbiter_if.master     mem
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    logic [ADDR_W-1:0] vga_addr, ntsc_addr, vga_eff, ntsc_eff;
    logic              pend_full;
    logic [MEM_W-1:0]  pend_data;
    logic              ntsc_ok, proc_ok, proc_first;
    grant_t            grant;
    tag_t              tag_issue, tag_ret;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_we_b;
    logic [MEM_W-1:0]  cmd_wdata;
    logic [MEM_W-1:0]  wdata_pipe [READ_LAT+1];

    // frame_flag restarts both counters in the same cycle it is seen.
    assign vga_eff  = frame_flag ? '0 : vga_addr;
    assign ntsc_eff = frame_flag ? '0 : ntsc_addr;
    assign ntsc_ok  = ntsc_flag || pend_full;
    // proc_ack marks the command cycle, while proc_req may legally still be high.
    assign proc_ok  = proc_req && !proc_ack;

`ifdef MEM_ARBITER_PROC_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_cnt;

    assign proc_first = (age_cnt >= AGE_W'(AGE_LIMIT));

    always_ff @(posedge clock) begin
        if (reset || grant == GNT_PROC) begin
            age_cnt <= '0;
        end else if (proc_ok && !proc_first) begin
            age_cnt <= age_cnt + AGE_W'(1);
        end
    end
`else
    assign proc_first = 1'b0;
`endif

    always_comb begin
        grant = GNT_IDLE;
        if (vga_flag)                    grant = GNT_VGA;
        else if (proc_ok && proc_first)  grant = GNT_PROC;
        else if (ntsc_ok)                grant = GNT_NTSC;
        else if (proc_ok)                grant = GNT_PROC;
    end

    always_comb begin
        cmd_addr  = mem.mem_addr;
        cmd_we_b  = 1'b1;
        cmd_wdata = '0;
        tag_issue = TAG_NONE;
        case (grant)
            GNT_VGA: begin
                cmd_addr  = vga_eff;
                tag_issue = TAG_VGA;
            end
            GNT_NTSC: begin
                cmd_addr  = ntsc_eff;
                cmd_we_b  = 1'b0;
                cmd_wdata = pend_full ? pend_data : ntsc_pixel;
            end
            GNT_PROC: begin
                cmd_addr  = proc_addr;
                cmd_we_b  = !proc_we;
                cmd_wdata = proc_we ? proc_wdata : '0;
                tag_issue = proc_we ? TAG_NONE : TAG_PROC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_addr      <= '0;
            ntsc_addr     <= '0;
            pend_full     <= 1'b0;
            pend_data     <= '0;
            ntsc_overflow <= 1'b0;
            proc_ack      <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_we_b  <= 1'b1;
        end else begin
            vga_addr     <= (grant == GNT_VGA)  ? wrap_inc(vga_eff, LAST_ADDR)  : vga_eff;
            ntsc_addr    <= (grant == GNT_NTSC) ? wrap_inc(ntsc_eff, LAST_ADDR) : ntsc_eff;
            proc_ack     <= (grant == GNT_PROC);
            mem.mem_addr <= cmd_addr;
            mem.mem_we_b <= cmd_we_b;
            // A full latch always drains before a newer word; the newer word is lost.
            if (ntsc_flag && pend_full) begin
                ntsc_overflow <= 1'b1;
                if (grant == GNT_NTSC) pend_full <= 1'b0;
            end else if (ntsc_flag && grant != GNT_NTSC) begin
                pend_full <= 1'b1;
                pend_data <= ntsc_pixel;
            end else if (grant == GNT_NTSC) begin
                pend_full <= 1'b0;
            end
        end
    end

    // ZBT takes write data READ_LAT cycles after the address cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= READ_LAT; i++) wdata_pipe[i] <= '0;
        end else begin
            wdata_pipe[0] <= cmd_wdata;
            for (int i = 1; i <= READ_LAT; i++) wdata_pipe[i] <= wdata_pipe[i-1];
        end
    end

    assign mem.mem_wdata = wdata_pipe[READ_LAT];

    mem_tag_pipe #(.DEPTH(READ_LAT + 1)) u_tag_pipe (
        .clock   (clock),
        .clear   (reset),
        .tag_in  (tag_issue),
        .tag_out (tag_ret)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            vga_pixel  <= '0;
            proc_rdata <= '0;
            done_vga   <= 1'b0;
            done_proc  <= 1'b0;
        end else begin
            done_vga  <= (tag_ret == TAG_VGA);
            done_proc <= (tag_ret == TAG_PROC);
            if (tag_ret == TAG_VGA)  vga_pixel  <= mem.mem_rdata;
            if (tag_ret == TAG_PROC) proc_rdata <= mem.mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the SRAM model returns address+0x100 after READ_LAT cycles.
module tb_mem_arbiter import mem_arbiter_pkg::*; ;

    // Short frame so the counter wrap is reachable in a few dozen cycles.
    localparam int TB_FW = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              frame_flag = 1'b0;
    logic              vga_flag = 1'b0;
    logic [MEM_W-1:0]  vga_pixel;
    logic              done_vga;
    logic              ntsc_flag = 1'b0;
    logic [MEM_W-1:0]  ntsc_pixel = '0;
    logic              ntsc_overflow;
    logic              proc_req = 1'b0;
    logic              proc_we = 1'b0;
    logic [ADDR_W-1:0] proc_addr = '0;
    logic [MEM_W-1:0]  proc_wdata = '0;
    logic              proc_ack;
    logic [MEM_W-1:0]  proc_rdata;
    logic              done_proc;

    logic [ADDR_W-1:0] addr_d1 = '0;
    logic [ADDR_W-1:0] addr_d2 = '0;

    int total  = 0;
    int passed = 0;

    mem_arbiter_if mem_bus ();

    mem_arbiter #(.FRAME_WORDS(TB_FW)) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_flag    (frame_flag),
        .vga_flag      (vga_flag),
        .vga_pixel     (vga_pixel),
        .done_vga      (done_vga),
        .ntsc_flag     (ntsc_flag),
        .ntsc_pixel    (ntsc_pixel),
        .ntsc_overflow (ntsc_overflow),
        .proc_req      (proc_req),
        .proc_we       (proc_we),
        .proc_addr     (proc_addr),
        .proc_wdata    (proc_wdata),
        .proc_ack      (proc_ack),
        .proc_rdata    (proc_rdata),
        .done_proc     (done_proc),
        .mem           (mem_bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        addr_d1 <= mem_bus.mem_addr;
        addr_d2 <= addr_d1;
    end

    assign mem_bus.mem_rdata = MEM_W'(addr_d2) + MEM_W'(36'h100);

    task automatic applyStimulus(input logic v, input logic n, input logic f,
                                 input logic [MEM_W-1:0] px);
        vga_flag   = v;
        ntsc_flag  = n;
        frame_flag = f;
        ntsc_pixel = px;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_vga_pixel"},  64'(vga_pixel),        64'h0);
        checkOutput({tag, "_proc_rdata"}, 64'(proc_rdata),       64'h0);
        checkOutput({tag, "_done_vga"},   64'(done_vga),         64'h0);
        checkOutput({tag, "_done_proc"},  64'(done_proc),        64'h0);
        checkOutput({tag, "_proc_ack"},   64'(proc_ack),         64'h0);
        checkOutput({tag, "_overflow"},   64'(ntsc_overflow),    64'h0);
        checkOutput({tag, "_mem_addr"},   64'(mem_bus.mem_addr), 64'h0);
        checkOutput({tag, "_mem_we_b"},   64'(mem_bus.mem_we_b), 64'h1);
        checkOutput({tag, "_mem_wdata"},  64'(mem_bus.mem_wdata),64'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkResetState("reset");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] VGA burst of three reads");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("vga0_addr", 64'(mem_bus.mem_addr), 64'h0);
        checkOutput("vga0_we_b", 64'(mem_bus.mem_we_b), 64'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("vga1_addr", 64'(mem_bus.mem_addr), 64'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("vga2_addr", 64'(mem_bus.mem_addr), 64'h2);
        checkOutput("vga_no_done_early", 64'(done_vga), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("vga0_done",  64'(done_vga),  64'h1);
        checkOutput("vga0_pixel", 64'(vga_pixel), 64'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("vga1_done",  64'(done_vga),  64'h1);
        checkOutput("vga1_pixel", 64'(vga_pixel), 64'h101);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("vga2_done",  64'(done_vga),  64'h1);
        checkOutput("vga2_pixel", 64'(vga_pixel), 64'h102);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("vga_done_ends", 64'(done_vga),  64'h0);
        checkOutput("vga_pixel_hold", 64'(vga_pixel), 64'h102);

        $display("[TB] VGA and NTSC together with frame_flag");
        applyStimulus(1'b1, 1'b1, 1'b1, 36'hABC);
        checkOutput("both_read_addr", 64'(mem_bus.mem_addr), 64'h0);
        checkOutput("both_read_we_b", 64'(mem_bus.mem_we_b), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("both_write_addr", 64'(mem_bus.mem_addr), 64'h0);
        checkOutput("both_write_we_b", 64'(mem_bus.mem_we_b), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("both_wdata_slot", 64'(mem_bus.mem_wdata), 64'hABC);
        checkOutput("both_vga_done",   64'(done_vga),          64'h1);
        checkOutput("both_vga_pixel",  64'(vga_pixel),         64'h100);
        checkOutput("both_no_overflow", 64'(ntsc_overflow),    64'h0);

        $display("[TB] NTSC overflow under a VGA run");
        applyStimulus(1'b1, 1'b1, 1'b0, 36'h111);
        checkOutput("ovf_read1", 64'(mem_bus.mem_addr), 64'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 36'h222);
        checkOutput("ovf_read2", 64'(mem_bus.mem_addr), 64'h2);
        checkOutput("ovf_flag",  64'(ntsc_overflow),    64'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("ovf_read3", 64'(mem_bus.mem_addr), 64'h3);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("ovf_write_addr", 64'(mem_bus.mem_addr), 64'h1);
        checkOutput("ovf_write_we_b", 64'(mem_bus.mem_we_b), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("ovf_single_write", 64'(mem_bus.mem_we_b), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("ovf_wdata", 64'(mem_bus.mem_wdata), 64'h111);
        applyStimulus(1'b0, 1'b1, 1'b0, 36'h333);
        checkOutput("ovf_next_ntsc_addr", 64'(mem_bus.mem_addr), 64'h2);
        checkOutput("ovf_next_ntsc_we_b", 64'(mem_bus.mem_we_b), 64'h0);
        checkOutput("ovf_sticky", 64'(ntsc_overflow), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);

        $display("[TB] processor read");
        proc_req  = 1'b1;
        proc_we   = 1'b0;
        proc_addr = 19'h1234;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("proc_rd_ack",  64'(proc_ack),         64'h1);
        checkOutput("proc_rd_addr", 64'(mem_bus.mem_addr), 64'h1234);
        checkOutput("proc_rd_we_b", 64'(mem_bus.mem_we_b), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("proc_rd_single_ack", 64'(proc_ack), 64'h0);
        proc_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("proc_rd_done",  64'(done_proc),  64'h1);
        checkOutput("proc_rd_data",  64'(proc_rdata), 64'h1334);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("proc_rd_done_ends", 64'(done_proc),  64'h0);
        checkOutput("proc_rd_data_hold", 64'(proc_rdata), 64'h1334);

        $display("[TB] processor write waits behind VGA");
        proc_req   = 1'b1;
        proc_we    = 1'b1;
        proc_addr  = 19'h55;
        proc_wdata = 36'h777;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("proc_wr_vga_first", 64'(mem_bus.mem_addr), 64'h4);
        checkOutput("proc_wr_no_ack",    64'(proc_ack),         64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("proc_wr_ack",  64'(proc_ack),         64'h1);
        checkOutput("proc_wr_addr", 64'(mem_bus.mem_addr), 64'h55);
        checkOutput("proc_wr_we_b", 64'(mem_bus.mem_we_b), 64'h0);
        proc_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("proc_wr_wdata", 64'(mem_bus.mem_wdata), 64'h777);
        checkOutput("proc_wr_no_done", 64'(done_proc), 64'h0);

        $display("[TB] VGA counter wrap and mid-frame restart");
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < TB_FW; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0);
        end
        checkOutput("wrap_last_addr", 64'(mem_bus.mem_addr), 64'(TB_FW - 1));
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("wrap_first_addr", 64'(mem_bus.mem_addr), 64'h0);
        checkOutput("wrap_stream_done", 64'(done_vga), 64'h1);
        checkOutput("wrap_stream_pixel", 64'(vga_pixel), 64'(TB_FW - 3) + 64'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("wrap_second_addr", 64'(mem_bus.mem_addr), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("frame_restart_addr", 64'(mem_bus.mem_addr), 64'h0);

        $display("[TB] reset while a VGA read is in flight");
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("inflight_addr", 64'(mem_bus.mem_addr), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkResetState("midreset");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("midreset_no_done_a", 64'(done_vga), 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("midreset_no_done_b", 64'(done_vga), 64'h0);
        checkOutput("midreset_pixel_zero", 64'(vga_pixel), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port arbiter for the shared pipelined ZBT frame-buffer SRAM.
- Three requesters share it: the VGA fetcher (read, hard real-time), the NTSC capture writer (write, soft real-time) and the processing engine (read/write, best effort).
- Maintains the VGA and NTSC linear address counters internally and tags in-flight reads so that each read returns to its issuer.
- Sits between vga_write / ntsc capture / processing and the SRAM pins.

Parameters:
- MEM_W, 36, SRAM word width (two packed 18-bit YCbCr pixels).
- ADDR_W, 19, SRAM address width.
- FRAME_WORDS, 153600, words per frame (640x480 / 2); counters wrap at FRAME_WORDS-1.
- READ_LAT, 2, SRAM read latency in cycles from the address cycle to valid mem_rdata.
- AGE_LIMIT, 16, processor wait cycles before aging promotion (optional feature only).

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- frame_flag, in, 1, start of frame; clears the VGA and NTSC address counters.
- vga_flag, in, 1, single-cycle VGA read request.
- vga_pixel, out, MEM_W, VGA read data.
- done_vga, out, 1, one-cycle pulse: vga_pixel is valid.
- ntsc_flag, in, 1, single-cycle capture write request.
- ntsc_pixel, in, MEM_W, capture write data, sampled with ntsc_flag.
- ntsc_overflow, out, 1, sticky: a capture write was lost.
- proc_req, in, 1, level request, held until proc_ack.
- proc_we, in, 1, 1 = write, 0 = read.
- proc_addr, in, ADDR_W, processor address.
- proc_wdata, in, MEM_W, processor write data.
- proc_ack, out, 1, one-cycle pulse: request accepted (command issued).
- proc_rdata, out, MEM_W, processor read data.
- done_proc, out, 1, one-cycle pulse: proc_rdata is valid.
- mem_addr, out, ADDR_W, SRAM address (registered).
- mem_we_b, out, 1, SRAM write enable, active-low (registered).
- mem_wdata, out, MEM_W, SRAM write data, aligned to the ZBT write-data slot (registered).
- mem_rdata, in, MEM_W, SRAM read data.

Behaviour:
- Reset values:
  - vga_pixel = 0, proc_rdata = 0.
  - done_vga = done_proc = proc_ack = 0.
  - ntsc_overflow = 0.
  - mem_addr = 0, mem_we_b = 1, mem_wdata = 0.
  - Both address counters = 0; NTSC pending latch empty; tag pipe cleared.
- Arbitration, every cycle, exactly one command or an idle (mem_we_b = 1, read of the last address, untagged):
  - Priority: VGA > NTSC (incoming ntsc_flag or pending latch) > processor.
- VGA:
  - Always granted in the cycle after vga_flag.
  - Issues a read at vga_addr; vga_addr increments, wrapping FRAME_WORDS-1 -> 0.
- NTSC:
  - If ntsc_flag arrives while VGA wins, the data is held in a 1-deep pending latch.
  - If ntsc_flag arrives while the latch is full: the pending entry is written first, the new word is dropped, and ntsc_overflow is set. It clears only on reset.
  - On a write grant, ntsc_addr increments with the same wrap rule as vga_addr.
- Processor:
  - When granted, proc_ack pulses during the command cycle.
  - The requester may change or drop proc_req the next cycle.
- Timing:
  - A request sampled at edge N drives its command on the bus during cycle N+1.
  - Read data is on mem_rdata during cycle N+1+READ_LAT.
  - Read data is registered into vga_pixel / proc_rdata, with the matching done_* pulse, at edge N+2+READ_LAT. This is 4 cycles with the defaults.
  - Output data holds until the next done for the same source.
- Tags:
  - A READ_LAT+1-stage tag shift register carries {NONE, VGA, PROC} per issued command.
  - Writes carry NONE.
  - Sustained back-to-back reads are allowed: one done per cycle maximum, in issue order.
- frame_flag:
  - Clears both counters in the same cycle.
  - If frame_flag and vga_flag are high together, the read uses address 0 and the counter becomes 1. NTSC follows the same rule.
  - Does not flush in-flight reads.
- Reset mid-operation: clears the tag pipe and the pending latch. No done_* pulse occurs for commands issued before reset.
- Processor starvation is permitted without the optional feature.

Optional Feature:
- Macro: MEM_ARBITER_PROC_AGING_EN.
- When defined:
  - A wait counter increments each cycle that proc_req is high and not acked.
  - Once the counter reaches AGE_LIMIT, the processor outranks NTSC (never VGA).
  - NTSC then uses the pending latch, with the same overflow rule.
  - The counter clears on proc_ack or reset.
- When undefined: no counter; fixed priority.

Decomposition:
- Shared package holds:
  - MEM_W, ADDR_W, FRAME_WORDS constants.
  - Source-tag typedef: TAG_NONE = 0, TAG_VGA = 1, TAG_PROC = 2 (2 bits).
- Sub-module mem_tag_pipe: a READ_LAT+1-deep tag shift register with synchronous clear. It outputs the returning tag used to steer the done pulses.

Test Plan:
- Reset, then vga_flag pulses at cycles 10, 11, 12 with mem_rdata modelled as address+0x100 at READ_LAT=2:
  - mem_addr = 0, 1, 2 at cycles 11–13.
  - done_vga at cycles 14–16 with vga_pixel = 0x100, 0x101, 0x102.
- vga_flag and ntsc_flag both high at cycle 5 (ntsc_pixel = 0xABC):
  - Cycle 6: read at address 0.
  - Cycle 7: write of 0xABC at ntsc address 0, mem_we_b = 0.
  - ntsc_overflow stays 0.
- vga_flag held high on 3 cycles while ntsc_flag pulses on cycles 1 and 2 of those 3:
  - The first word is written after the VGA run.
  - ntsc_overflow = 1.
  - ntsc address advances by 1 only.
- proc_req read at address 0x1234 with VGA idle:
  - proc_ack next cycle, mem_addr = 0x1234.
  - done_proc 3 cycles after the ack, with proc_rdata = mem_rdata.
- Counter wrap: 153600 vga_flag requests, then one more:
  - The last request of the run uses address 153599; the next uses 0.
  - frame_flag mid-frame forces address 0 on the following read.
- Reset asserted one cycle after a VGA read is issued:
  - No done_vga is pulsed.
  - All outputs are at their reset values the cycle after reset.
